// File: rtl/truss_watchdog_pkg.sv
// Shared types and helpers for the truss watchdog array.
//   wd_state_e   : per-channel watchdog state (IDLE, ARMED, WARN, EXPIRED)
//   clog2_min1() : $clog2 clamped to at least 1, used to size channel indices
package truss_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_ARMED   = 2'd1,
        WD_WARN    = 2'd2,
        WD_EXPIRED = 2'd3
    } wd_state_e;

    // A single-channel array still needs a 1-bit index port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/truss_watchdog_channel.sv
// One watchdog channel: a down-counter with a reload register and a
// four-state FSM (IDLE, ARMED, WARN, EXPIRED).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   tick            : prescaler enable for the decrement
//   arm, kick,      : per-channel commands, priority disarm > arm > kick > tick
//   disarm
//   timeout_value   : load value used by arm
//   active, warn,   : state decodes (all derived from registered state)
//   expired
//   expired_pulse   : one-cycle pulse on each entry to EXPIRED
module truss_watchdog_channel
    import truss_watchdog_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int WARN_MARGIN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 arm,
    input  logic                 kick,
    input  logic                 disarm,
    input  logic [CNT_WIDTH-1:0] timeout_value,
    output logic                 active,
    output logic                 warn,
    output logic                 expired,
    output logic                 expired_pulse
);

    localparam logic [CNT_WIDTH-1:0] WARN_LIM = CNT_WIDTH'(WARN_MARGIN);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    wd_state_e            state_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] reload_q;
    logic                 pulse_q;
    logic                 running;
    logic [CNT_WIDTH-1:0] count_dec;

    assign running   = (state_q == WD_ARMED) || (state_q == WD_WARN);
    assign count_dec = count_q - CNT_ONE;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers, independent of
    // statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WD_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (disarm) begin
                state_q <= WD_IDLE;
                count_q <= CNT_ZERO;
            end else if (arm) begin
                reload_q <= timeout_value;
                count_q  <= timeout_value;
                if (timeout_value == CNT_ZERO) begin
                    // A zero timeout expires immediately, even when re-armed
                    // from EXPIRED, so the pulse fires again.
                    state_q <= WD_EXPIRED;
                    pulse_q <= 1'b1;
                end else if (timeout_value <= WARN_LIM) begin
                    state_q <= WD_WARN;
                end else begin
                    state_q <= WD_ARMED;
                end
            end else if (kick && running) begin
                // reload_q is non-zero here: a zero arm never reaches ARMED/WARN.
                count_q <= reload_q;
                state_q <= (reload_q <= WARN_LIM) ? WD_WARN : WD_ARMED;
            end else if (tick && running) begin
                if (count_q == CNT_ONE) begin
                    state_q <= WD_EXPIRED;
                    count_q <= CNT_ZERO;
                    pulse_q <= 1'b1;
                end else begin
                    count_q <= count_dec;
                    if (count_dec <= WARN_LIM) begin
                        state_q <= WD_WARN;
                    end
                end
            end
        end
    end

    assign active        = running;
    assign warn          = (state_q == WD_WARN);
    assign expired       = (state_q == WD_EXPIRED);
    assign expired_pulse = pulse_q;

endmodule

// File: rtl/truss_watchdog_array.sv
// Multi-channel watchdog: NUM_CHANNELS independent channels plus a latch
// recording the lowest-indexed channel among the first to expire.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   tick             : shared prescaler enable
//   arm/kick/disarm  : per-channel command vectors
//   timeout_value    : packed load values, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   clear_first      : clears the first-expiry latch
//   active/warn/expired/expired_pulse : per-channel status vectors
//   any_expired      : OR of expired
//   first_valid, first_expired_id : first-expiry latch
module truss_watchdog_array
    import truss_watchdog_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int WARN_MARGIN  = 16,
    parameter int ID_WIDTH     = clog2_min1(NUM_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic [NUM_CHANNELS-1:0]           arm,
    input  logic [NUM_CHANNELS-1:0]           kick,
    input  logic [NUM_CHANNELS-1:0]           disarm,
    input  logic [NUM_CHANNELS*CNT_WIDTH-1:0] timeout_value,
    input  logic                              clear_first,
    output logic [NUM_CHANNELS-1:0]           active,
    output logic [NUM_CHANNELS-1:0]           warn,
    output logic [NUM_CHANNELS-1:0]           expired,
    output logic [NUM_CHANNELS-1:0]           expired_pulse,
    output logic                              any_expired,
    output logic                              first_valid,
    output logic [ID_WIDTH-1:0]               first_expired_id
);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        truss_watchdog_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .WARN_MARGIN (WARN_MARGIN)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .tick          (tick),
            .arm           (arm[g]),
            .kick          (kick[g]),
            .disarm        (disarm[g]),
            .timeout_value (timeout_value[g*CNT_WIDTH +: CNT_WIDTH]),
            .active        (active[g]),
            .warn          (warn[g]),
            .expired       (expired[g]),
            .expired_pulse (expired_pulse[g])
        );
    end

    assign any_expired = |expired;

    // Lowest pulsing index wins; scanning downward lets it overwrite higher hits.
    logic [ID_WIDTH-1:0] low_idx;

    // NOTE: low_idx gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (expired_pulse[i]) begin
                low_idx = ID_WIDTH'(i);
            end
        end
    end

    logic                first_valid_q;
    logic [ID_WIDTH-1:0] first_id_q;

    // Clear then load: a pulse seen in the same cycle as clear_first is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
        end else begin
            if (clear_first) begin
                first_valid_q <= 1'b0;
                first_id_q    <= '0;
            end
            if ((!first_valid_q || clear_first) && (|expired_pulse)) begin
                first_valid_q <= 1'b1;
                first_id_q    <= low_idx;
            end
        end
    end

    assign first_valid      = first_valid_q;
    assign first_expired_id = first_id_q;

endmodule

// File: tb/tb_truss_watchdog_array.sv
// Self-checking bench for truss_watchdog_array: a behavioural model (remaining
// count + live/expired flags per channel) is compared against the DUT on every
// falling edge, with directed scenarios carrying hand-computed expectations
// followed by a randomized soak.
module tb_truss_watchdog_array;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int WM  = 16;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               tick = 1'b0;
    logic [NCH-1:0]     arm = '0;
    logic [NCH-1:0]     kick = '0;
    logic [NCH-1:0]     disarm = '0;
    logic [NCH*CW-1:0]  timeout_value = '0;
    logic               clear_first = 1'b0;
    logic [NCH-1:0]     active, warn, expired, expired_pulse;
    logic               any_expired, first_valid;
    logic [IDW-1:0]     first_expired_id;

    truss_watchdog_array #(
        .NUM_CHANNELS (NCH),
        .CNT_WIDTH    (CW),
        .WARN_MARGIN  (WM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .arm              (arm),
        .kick             (kick),
        .disarm           (disarm),
        .timeout_value    (timeout_value),
        .clear_first      (clear_first),
        .active           (active),
        .warn             (warn),
        .expired          (expired),
        .expired_pulse    (expired_pulse),
        .any_expired      (any_expired),
        .first_valid      (first_valid),
        .first_expired_id (first_expired_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A channel is "live" while counting; remaining ticks to expiry in m_rem.
    bit m_live  [NCH] = '{default: 1'b0};
    bit m_exp   [NCH] = '{default: 1'b0};
    bit m_pulse [NCH] = '{default: 1'b0};
    int m_rem   [NCH] = '{default: 0};
    int m_rel   [NCH] = '{default: 0};
    bit m_fv  = 1'b0;
    int m_fid = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_live[i] = 0; m_exp[i] = 0; m_pulse[i] = 0; m_rem[i] = 0; m_rel[i] = 0;
            end
            m_fv = 0; m_fid = 0;
        end else begin
            bit any_p;
            int low;
            any_p = 0; low = 0;
            for (int i = NCH - 1; i >= 0; i--) if (m_pulse[i]) begin any_p = 1; low = i; end
            if (clear_first) begin m_fv = 0; m_fid = 0; end
            if ((!m_fv || clear_first) && any_p) begin m_fv = 1; m_fid = low; end
            for (int i = 0; i < NCH; i++) begin
                int v;
                v = int'(timeout_value[i*CW +: CW]);
                m_pulse[i] = 0;
                if (disarm[i]) begin
                    m_live[i] = 0; m_exp[i] = 0; m_rem[i] = 0;
                end else if (arm[i]) begin
                    m_rel[i] = v; m_rem[i] = v;
                    m_live[i] = (v != 0); m_exp[i] = (v == 0); m_pulse[i] = (v == 0);
                end else if (kick[i] && m_live[i]) begin
                    m_rem[i] = m_rel[i];
                end else if (tick && m_live[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin m_live[i] = 0; m_exp[i] = 1; m_pulse[i] = 1; end
                end
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NCH-1:0] e_act, e_warn, e_exp, e_pulse;
            for (int i = 0; i < NCH; i++) begin
                e_act[i]   = m_live[i];
                e_warn[i]  = m_live[i] && (m_rem[i] <= WM);
                e_exp[i]   = m_exp[i];
                e_pulse[i] = m_pulse[i];
            end
            check("model active", int'(active), int'(e_act));
            check("model warn", int'(warn), int'(e_warn));
            check("model expired", int'(expired), int'(e_exp));
            check("model expired_pulse", int'(expired_pulse), int'(e_pulse));
            check("model any_expired", int'(any_expired), int'(|e_exp));
            check("model first_valid", int'(first_valid), int'(m_fv));
            if (m_fv) check("model first_expired_id", int'(first_expired_id), m_fid);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clr_cmds();
        arm = '0; kick = '0; disarm = '0; clear_first = 1'b0;
    endtask

    task automatic set_tv(input int ch, input int v);
        timeout_value[ch*CW +: CW] = CW'(v);
    endtask

    initial begin
        int pulse_at;

        // Reset
        reset = 1'b1;
        steps(2);
        cmp_en = 1'b1;
        check("reset active", int'(active), 0);
        check("reset expired", int'(expired), 0);
        check("reset first_valid", int'(first_valid), 0);
        reset = 1'b0;
        tick  = 1'b1;

        // arm[0]=5: warn immediately, expire on 5th tick
        set_tv(0, 5); arm[0] = 1'b1;
        step(); clr_cmds();
        check("arm5 active0", int'(active[0]), 1);
        check("arm5 warn0", int'(warn[0]), 1);
        steps(4);
        check("arm5 not yet expired", int'(expired[0]), 0);
        step();
        check("arm5 pulse on 5th tick", int'(expired_pulse[0]), 1);
        step();
        check("arm5 pulse one cycle", int'(expired_pulse[0]), 0);
        check("arm5 first_valid", int'(first_valid), 1);
        check("arm5 first id", int'(first_expired_id), 0);

        // arm[1]=40 kicked every 20 ticks: never warns
        set_tv(1, 40); arm[1] = 1'b1;
        step(); clr_cmds();
        for (int k = 0; k < 10; k++) begin
            steps(19);
            kick[1] = 1'b1;
            step(); clr_cmds();
            check("kick40 no warn", int'(warn[1]), 0);
        end
        steps(23);
        check("kick40 warn at 17", int'(warn[1]), 0);
        step();
        check("kick40 warn at 16", int'(warn[1]), 1);
        steps(15);
        check("kick40 not expired at 1", int'(expired[1]), 0);
        step();
        check("kick40 expiry 40 after kick", int'(expired_pulse[1]), 1);
        step();
        check("kick40 first id held", int'(first_expired_id), 0);

        // Simultaneous expiry of 2 and 3 after clear_first
        clear_first = 1'b1;
        set_tv(2, 10); set_tv(3, 10); arm[2] = 1'b1; arm[3] = 1'b1;
        step(); clr_cmds();
        check("clear first_valid", int'(first_valid), 0);
        steps(10);
        check("dual pulse", int'(expired_pulse[3:2]), 3);
        step();
        check("dual first id", int'(first_expired_id), 2);
        set_tv(1, 3); arm[1] = 1'b1;
        step(); clr_cmds();
        steps(4);
        check("ch1 re-expired", int'(expired[1]), 1);
        check("later expiry keeps id", int'(first_expired_id), 2);
        clear_first = 1'b1;
        step(); clr_cmds();
        check("clear_first valid", int'(first_valid), 0);

        // arm 0: immediate expiry, kick ignored, re-arm clears
        set_tv(0, 0); arm[0] = 1'b1;
        step(); clr_cmds();
        check("arm0 expired", int'(expired[0]), 1);
        check("arm0 pulse", int'(expired_pulse[0]), 1);
        kick[0] = 1'b1;
        step(); clr_cmds();
        check("arm0 kick ignored", int'(expired[0]), 1);
        check("arm0 kick not active", int'(active[0]), 0);
        set_tv(0, 30); arm[0] = 1'b1;
        step(); clr_cmds();
        check("rearm30 expired cleared", int'(expired[0]), 0);
        check("rearm30 armed not warn", int'({active[0], warn[0]}), 2);

        // Sparse tick: arm 3, tick every 4th cycle -> pulse after cycle 12
        tick = 1'b0;
        set_tv(3, 3); arm[3] = 1'b1;
        step(); clr_cmds();
        pulse_at = -1;
        for (int c = 1; c <= 24; c++) begin
            tick = (c % 4 == 0);
            step();
            if (expired_pulse[3]) begin pulse_at = c; break; end
        end
        check("sparse tick expiry cycle", pulse_at, 12);
        tick = 1'b1;
        set_tv(3, 20); disarm[3] = 1'b1; arm[3] = 1'b1;
        step(); clr_cmds();
        check("disarm beats arm", int'({active[3], expired[3]}), 0);

        // Reset mid-count with a simultaneous kick
        set_tv(2, 10); arm[2] = 1'b1;
        step(); clr_cmds();
        steps(3);
        reset = 1'b1; kick[2] = 1'b1;
        step(); clr_cmds(); reset = 1'b0;
        check("midreset active", int'(active), 0);
        check("midreset warn", int'(warn), 0);
        check("midreset expired", int'(expired), 0);
        check("midreset first_valid", int'(first_valid), 0);
        steps(20);
        check("midreset no later expiry", int'(any_expired), 0);

        // Randomized soak against the model
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            tick        = ($urandom_range(0, 3) != 0);
            clear_first = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NCH; i++) begin
                arm[i]    = ($urandom_range(0, 19) == 0);
                kick[i]   = ($urandom_range(0, 7) == 0);
                disarm[i] = ($urandom_range(0, 49) == 0);
                set_tv(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40)));
            end
            step();
        end
        reset = 1'b0; clr_cmds();
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truss_watchdog_array.md
Name: truss_watchdog_array

Overview:
- Parametrised, synthesizable multi-channel hardware watchdog: N independent timeout counters, each armed, kicked and disarmed by the bench or the DUT wrapper.
- Each channel raises an early warning before it expires, then a sticky timeout.
- The block latches which channel expired first, so the truss shutdown/test layer can report the root cause instead of only "watchdog fired".
- Sits beside the DUT in the testbench top as the RTL successor of the single-timer watchdog.

Parameters:
- NUM_CHANNELS, 4, number of independent watchdog channels (1..32)
- CNT_WIDTH, 16, width of each timeout counter and of each timeout_value slice
- WARN_MARGIN, 16, a channel enters WARN when its remaining count is <= this value (must be < 2**CNT_WIDTH)
- ID_WIDTH, $clog2(NUM_CHANNELS) (minimum 1), width of first_expired_id

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- tick  in  1  prescaler enable; counters decrement only in cycles where tick=1 (tie high for per-clock counting)
- arm  in  NUM_CHANNELS  per-channel; loads timeout_value slice and starts the channel
- kick  in  NUM_CHANNELS  per-channel; reloads the last armed value
- disarm  in  NUM_CHANNELS  per-channel; returns the channel to IDLE and clears its expired bit
- timeout_value  in  NUM_CHANNELS*CNT_WIDTH  packed per-channel load values; channel i uses bits [i*CNT_WIDTH +: CNT_WIDTH]
- clear_first  in  1  clears the first-expiry latch
- active  out  NUM_CHANNELS  channel is in ARMED or WARN
- warn  out  NUM_CHANNELS  channel is in WARN
- expired  out  NUM_CHANNELS  sticky; channel is in EXPIRED
- expired_pulse  out  NUM_CHANNELS  one-cycle pulse on entry to EXPIRED
- any_expired  out  1  OR of expired
- first_valid  out  1  first-expiry latch holds a value
- first_expired_id  out  ID_WIDTH  index of the first channel to expire since reset or clear_first

Behaviour:
- Reset: all channels IDLE; counters and reload registers 0; all outputs 0.
- Per-channel FSM states: IDLE, ARMED, WARN, EXPIRED. All outputs are registered, i.e. valid the cycle after the causing edge.
- Command priority per channel, same cycle: disarm > arm > kick > tick-decrement.
- arm, from any state: reload := value, count := value. Next state is ARMED if value > WARN_MARGIN, else WARN. If value = 0, the channel goes straight to EXPIRED with expired_pulse.
- kick: in ARMED/WARN, count := reload, and the state is re-evaluated against WARN_MARGIN. Ignored in IDLE and EXPIRED (expiry is not kickable; re-arm instead).
- tick in ARMED/WARN:
  - count = 1: next state EXPIRED, count := 0, expired_pulse for one cycle.
  - otherwise: count := count-1; ARMED moves to WARN when the new count <= WARN_MARGIN.
  - A timeout of V therefore expires on the V-th tick after arm.
- disarm: next state IDLE, count := 0; clears expired and warn.
- Counters never wrap: no decrement occurs in IDLE or EXPIRED.
- First-expiry latch:
  - Load when first_valid=0 and any expired_pulse is set: first_valid := 1, first_expired_id := lowest index among the simultaneously pulsing channels.
  - Later expiries do not update it.
  - clear_first clears first_valid and first_expired_id to 0. If clear_first coincides with a new pulse, the new pulse is latched (clear then load).
- reset asserted mid-count: all state is discarded at that edge; any arm/kick in the same cycle is ignored.

Decomposition:
- Package truss_watchdog_pkg holds:
  - wd_state_e enum (IDLE, ARMED, WARN, EXPIRED; 2-bit)
  - a clog2-min-1 helper function for ID_WIDTH
- Sub-module truss_watchdog_channel holds one FSM and counter (params CNT_WIDTH, WARN_MARGIN).
- Top generates NUM_CHANNELS instances and contains the priority encoder and first-expiry latch.

Test Plan:
- Reset then arm[0] with value 5, tick=1 each cycle -> active[0]=1; warn[0]=1 immediately (5 <= 16); expired_pulse[0] on the 5th tick; first_valid=1, first_expired_id=0.
- CNT_WIDTH=16, arm[1] with value 40, kick[1] every 20 ticks, 10 times -> no expiry; warn[1] never asserts; stop kicking -> warn at count 16, expiry 40 ticks after the last kick.
- arm[2]=10 and arm[3]=10 in the same cycle -> both expire on the same cycle; first_expired_id=2; a later expiry of channel 1 leaves the id at 2 until clear_first.
- arm[0]=0 -> expired[0]=1 and one expired_pulse the next cycle; kick[0] ignored; arm[0]=30 clears expired and restarts in ARMED.
- tick=1 every 4th cycle, arm value 3 -> expiry after 3 ticks (about 12 clks), count held between ticks; disarm+arm in the same cycle -> channel goes IDLE.
- reset asserted at count 7 with a simultaneous kick -> all outputs 0 next cycle, channel IDLE; no expiry follows without a new arm.
